// File: rtl/mod_n_counter_if.sv
// Control and status bundle for mod_n_counter.
// master: the block driving control (en, up_dn, clr, load, load_val).
// slave:  the counter itself, returning count, tc, wrap and err.
interface mod_n_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             err;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  count, tc, wrap, err
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output count, tc, wrap, err
  );
endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with synchronous clear/load, terminal-count flag,
// registered wrap pulse and sticky out-of-range-load error.
// Optional enable prescaler: define MODULUS_CNT_PRESCALE_EN to count only every
// PRESCALE-th enabled cycle; undefined builds have no prescaler and en_eff = en.
module mod_n_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 7,
  parameter int unsigned PRESCALE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mod_n_counter_if.slave bus
);

  if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_n_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_n_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             en_eff;
  logic             at_top;
  logic             at_zero;
  logic             load_ok;

`ifdef MODULUS_CNT_PRESCALE_EN
  localparam int unsigned    PsWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsWidth-1:0] PsLast = PsWidth'(PRESCALE - 1);

  logic [PsWidth-1:0] ps_q, ps_d;

  // Prescaler: counts en-high cycles, restarts on clr/load so spacing is relative to them.
  always_comb begin
    ps_d = ps_q;
    if (bus.clr || bus.load) begin
      ps_d = '0;
    end else if (bus.en) begin
      ps_d = (ps_q == PsLast) ? '0 : ps_q + PsWidth'(1);
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  assign en_eff = bus.en & (ps_q == PsLast);
`else
  assign en_eff = bus.en;
`endif

  assign at_top  = (count_q == MaxCount);
  assign at_zero = (count_q == '0);
  // Compare in 32 bits so MODULUS == 2**WIDTH accepts every load value.
  assign load_ok = (32'(bus.load_val) < MODULUS);

  // Next-state: clr > load > enabled step > hold; wrap only set by a wrapping step.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    if (bus.clr) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (bus.load) begin
      if (load_ok) begin
        count_d = bus.load_val;
      end else begin
        count_d = MaxCount;
        err_d   = 1'b1;
      end
    end else if (en_eff) begin
      if (bus.up_dn) begin
        if (at_top) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          count_d = MaxCount;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Counter, wrap pulse and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
  assign bus.tc    = en_eff & ~bus.clr & ~bus.load &
                     ((bus.up_dn & at_top) | (~bus.up_dn & at_zero));

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: default 7-state counter, a full-range
// WIDTH=3/MODULUS=8 instance, and (with MODULUS_CNT_PRESCALE_EN) a PRESCALE=4 instance.
module tb_mod_n_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mod_n_counter_if #(.WIDTH(4)) b ();
  mod_n_counter_if #(.WIDTH(3)) f ();

  mod_n_counter #(.WIDTH(4), .MODULUS(7), .PRESCALE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  mod_n_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) dut_full (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f.slave)
  );

`ifdef MODULUS_CNT_PRESCALE_EN
  mod_n_counter_if #(.WIDTH(4)) p ();
  mod_n_counter #(.WIDTH(4), .MODULUS(7), .PRESCALE(4)) dut_ps (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (p.slave)
  );
`endif

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string name, input logic [3:0] cnt, input logic wr, input logic er,
                      input logic [3:0] ecnt, input logic ewr, input logic eer);
    total++;
    if (cnt !== ecnt || wr !== ewr || er !== eer) begin
      bad++;
      $display("FAIL %s: count=%0d wrap=%b err=%b, want count=%0d wrap=%b err=%b",
               name, cnt, wr, er, ecnt, ewr, eer);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (b.count !== 4'd0 || b.wrap !== 1'b0 || b.err !== 1'b0 || b.tc !== 1'b0) begin
      bad++;
      $display("FAIL reset: count=%0d wrap=%b err=%b tc=%b, want 0 0 0 0",
               b.count, b.wrap, b.err, b.tc);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_count_up();
    logic [3:0] exp_cnt [8];
    logic [3:0] prev;
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd1};
    prev = 4'd0;
    b.up_dn = 1'b1;
    b.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (b.tc !== (prev == 4'd6)) begin
        bad++;
        $display("FAIL up_tc[%0d]: tc=%b want=%b", i, b.tc, prev == 4'd6);
      end
      tick();
      chk3("up_step", b.count, b.wrap, b.err, exp_cnt[i], (i == 6), 1'b0);
      prev = exp_cnt[i];
    end
    b.en = 1'b0;
  endtask

  task automatic test_count_down();
    b.clr = 1'b1;
    tick();
    b.clr = 1'b0;
    chk3("down_clr", b.count, b.wrap, b.err, 4'd0, 1'b0, 1'b0);
    b.up_dn = 1'b0;
    b.en = 1'b1;
    #1;
    total++;
    if (b.tc !== 1'b1) begin
      bad++;
      $display("FAIL down_tc: tc=%b want=1", b.tc);
    end
    tick();
    chk3("down_6", b.count, b.wrap, b.err, 4'd6, 1'b1, 1'b0);
    tick();
    chk3("down_5", b.count, b.wrap, b.err, 4'd5, 1'b0, 1'b0);
    tick();
    chk3("down_4", b.count, b.wrap, b.err, 4'd4, 1'b0, 1'b0);
    b.en = 1'b0;
  endtask

  task automatic test_load();
    b.up_dn = 1'b1;
    b.load = 1'b1;
    b.load_val = 4'd5;
    tick();
    b.load = 1'b0;
    chk3("load_5", b.count, b.wrap, b.err, 4'd5, 1'b0, 1'b0);
    b.en = 1'b1;
    tick();
    chk3("load_then_6", b.count, b.wrap, b.err, 4'd6, 1'b0, 1'b0);
    // tc must be masked while a load is pending even at the terminal count.
    b.load = 1'b1;
    b.load_val = 4'd9;
    #1;
    total++;
    if (b.tc !== 1'b0) begin
      bad++;
      $display("FAIL load_tc_mask: tc=%b want=0", b.tc);
    end
    b.load = 1'b0;
    tick();
    chk3("load_then_0", b.count, b.wrap, b.err, 4'd0, 1'b1, 1'b0);
    b.en = 1'b0;
    b.load = 1'b1;
    tick();
    b.load = 1'b0;
    chk3("load_9_sat", b.count, b.wrap, b.err, 4'd6, 1'b0, 1'b1);
    b.en = 1'b1;
    tick();
    chk3("err_hold_0", b.count, b.wrap, b.err, 4'd0, 1'b1, 1'b1);
    tick();
    chk3("err_hold_1", b.count, b.wrap, b.err, 4'd1, 1'b0, 1'b1);
    b.en = 1'b0;
    b.clr = 1'b1;
    tick();
    b.clr = 1'b0;
    chk3("clr_err", b.count, b.wrap, b.err, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    b.up_dn = 1'b1;
    b.load = 1'b1;
    b.load_val = 4'd4;
    tick();
    chk3("prio_setup", b.count, b.wrap, b.err, 4'd4, 1'b0, 1'b0);
    b.clr = 1'b1;
    b.en = 1'b1;
    b.load_val = 4'd2;
    tick();
    chk3("prio_clr", b.count, b.wrap, b.err, 4'd0, 1'b0, 1'b0);
    b.clr = 1'b0;
    b.load_val = 4'd3;
    tick();
    chk3("prio_load_en", b.count, b.wrap, b.err, 4'd3, 1'b0, 1'b0);
    b.load_val = 4'd6;
    tick();
    // Loading at the top with en high must not step or pulse wrap.
    tick();
    chk3("prio_load_top", b.count, b.wrap, b.err, 4'd6, 1'b0, 1'b0);
    b.load = 1'b0;
    b.en = 1'b0;
    #1;
    total++;
    if (b.tc !== 1'b0) begin
      bad++;
      $display("FAIL hold_tc: tc=%b want=0", b.tc);
    end
    tick();
    chk3("hold", b.count, b.wrap, b.err, 4'd6, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    b.up_dn = 1'b1;
    b.load = 1'b1;
    b.load_val = 4'd9;
    tick();
    b.load = 1'b0;
    b.en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk3("pre_rst", b.count, b.wrap, b.err, 4'd3, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("async_rst", b.count, b.wrap, b.err, 4'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk3("post_rst", b.count, b.wrap, b.err, 4'd1, 1'b0, 1'b0);
    b.en = 1'b0;
  endtask

  task automatic test_full_range();
    f.up_dn = 1'b1;
    f.load = 1'b1;
    f.load_val = 3'd7;
    tick();
    f.load = 1'b0;
    chk3("full_load7", {1'b0, f.count}, f.wrap, f.err, 4'd7, 1'b0, 1'b0);
    f.en = 1'b1;
    #1;
    total++;
    if (f.tc !== 1'b1) begin
      bad++;
      $display("FAIL full_tc_up: tc=%b want=1", f.tc);
    end
    tick();
    chk3("full_wrap_up", {1'b0, f.count}, f.wrap, f.err, 4'd0, 1'b1, 1'b0);
    f.up_dn = 1'b0;
    tick();
    chk3("full_wrap_dn", {1'b0, f.count}, f.wrap, f.err, 4'd7, 1'b1, 1'b0);
    tick();
    chk3("full_dn_6", {1'b0, f.count}, f.wrap, f.err, 4'd6, 1'b0, 1'b0);
    f.en = 1'b0;
  endtask

`ifdef MODULUS_CNT_PRESCALE_EN
  task automatic test_prescale();
    logic [3:0] ecnt;
    p.up_dn = 1'b1;
    p.clr = 1'b1;
    tick();
    p.clr = 1'b0;
    p.en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      ecnt = 4'(i / 4);
      chk3("ps_run", p.count, p.wrap, p.err, ecnt, 1'b0, 1'b0);
    end
    tick();
    tick();
    p.load = 1'b1;
    p.load_val = 4'd0;
    tick();
    p.load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      ecnt = (i == 4) ? 4'd1 : 4'd0;
      chk3("ps_reload", p.count, p.wrap, p.err, ecnt, 1'b0, 1'b0);
    end
    p.en = 1'b0;
  endtask
`endif

  initial begin
    b.en = 1'b0; b.up_dn = 1'b1; b.clr = 1'b0; b.load = 1'b0; b.load_val = '0;
    f.en = 1'b0; f.up_dn = 1'b1; f.clr = 1'b0; f.load = 1'b0; f.load_val = '0;
`ifdef MODULUS_CNT_PRESCALE_EN
    p.en = 1'b0; p.up_dn = 1'b1; p.clr = 1'b0; p.load = 1'b0; p.load_val = '0;
`endif
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_priority();
    test_async_reset();
    test_full_range();
`ifdef MODULUS_CNT_PRESCALE_EN
    test_prescale();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
